// File: rtl/sqrt_sched_pkg.sv
// Shared types and helpers for the square-root request scheduler.
// Tag and response entry layouts plus the invalid-operation predicate.
package sqrt_sched_pkg;

    localparam int FP_W     = 32;
    // Widest requester index a tag can carry (up to 16 requesters).
    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                nv;
    } sqrt_tag_t;

    typedef struct packed {
        logic [FP_W-1:0]     data;
        logic [TAG_ID_W-1:0] id;
        logic                nv;
    } resp_entry_t;

    // Negative, non-zero, non-NaN operands have no real square root.
    function automatic logic fp_sqrt_nv(input logic [FP_W-1:0] op);
        logic is_zero;
        logic is_nan;
        is_zero = (op[30:0] == 31'd0);
        is_nan  = (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
        return op[31] & ~is_zero & ~is_nan;
    endfunction

endpackage

// File: rtl/sqrt_req_scheduler_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic             found;
    int               idx_i;

    // Search from the pointer upward, wrapping, for the first request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_i     = 0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx_i = (int'(ptr) + k) % N;
            idx   = IDX_W'(idx_i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Winner drops to lowest priority once its grant is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sqrt_req_scheduler.sv
// Shares one fixed-latency square-root datapath among several requesters.
// Credit-limited issue, tag pipe alongside the datapath, in-order response FIFO.
module sqrt_req_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int SQRT_LAT   = 1,
    parameter  int RESP_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           sqrt_operand,
    input  logic [31:0]           sqrt_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_nv,
    output logic                  busy
);

    localparam int PIPE_D = SQRT_LAT + 1;
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    grant_idx;
    logic               can_issue;
    logic               issue;
    logic [FP_W-1:0]    op_sel;
    sqrt_tag_t          new_tag;

    sqrt_tag_t          tag_pipe [PIPE_D];
    logic [PIPE_D-1:0]  tag_valid;
    int                 inflight;

    resp_entry_t        fifo_mem [RESP_DEPTH];
    resp_entry_t        head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (issue),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    // Outstanding work is everything in the tag pipe plus the FIFO.
    always_comb begin
        inflight = 0;
        for (int k = 0; k < PIPE_D; k++) begin
            tag_valid[k] = tag_pipe[k].valid;
            if (tag_pipe[k].valid) begin
                inflight = inflight + 1;
            end
        end
        can_issue = (inflight + int'(count)) < RESP_DEPTH;
    end

    // Grant only when a FIFO slot is guaranteed for the result.
    always_comb begin
        req_ready = '0;
        if (can_issue && !rst) begin
            req_ready = arb_grant;
        end
        issue = |req_ready;
    end

    // Select the winning operand and build its tag.
    always_comb begin
        op_sel        = req_data[int'(grant_idx)*FP_W +: FP_W];
        new_tag       = '0;
        new_tag.valid = issue;
        new_tag.id    = TAG_ID_W'(grant_idx);
        new_tag.nv    = fp_sqrt_nv(op_sel);
    end

    // Operand register feeding the datapath; holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sqrt_operand <= '0;
        end else if (issue) begin
            sqrt_operand <= op_sel;
        end
    end

    // Tag shift register tracks each operand through the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_D; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= new_tag;
            for (int k = 1; k < PIPE_D; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign push = tag_pipe[PIPE_D-1].valid;
    assign pop  = resp_valid & resp_ready;

    // FIFO storage; contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {sqrt_result,
                                 tag_pipe[PIPE_D-1].id,
                                 tag_pipe[PIPE_D-1].nv};
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // First-word fall-through view of the FIFO head.
    always_comb begin
        head       = fifo_mem[rd_ptr];
        resp_valid = (count != '0);
        resp_data  = head.data;
        resp_id    = ID_W'(head.id);
        resp_nv    = head.nv;
        busy       = (|tag_valid) | (count != '0);
    end

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Randomised and directed bench for sqrt_req_scheduler.
// A queue-based reference model predicts every output each cycle.
module tb_sqrt_req_scheduler;

    localparam int NR    = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [31:0]     sqrt_operand;
    logic [31:0]     sqrt_result;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [1:0]      resp_id;
    logic            resp_nv;
    logic            busy;

    typedef struct {
        logic [31:0] data;
        int          id;
        bit          nv;
        int          rem;
    } op_t;

    int          errors = 0;
    int          checks = 0;
    op_t         inflight [$];
    op_t         fifoq [$];
    op_t         resp_log [$];
    int          grant_log [$];
    int          ptr;
    logic [31:0] last_op;
    int          exp_gnt;
    bit          pend [NR];
    logic [31:0] pdata [NR];
    logic [31:0] specials [8];

    sqrt_req_scheduler #(
        .NUM_REQ    (NR),
        .SQRT_LAT   (LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .sqrt_operand (sqrt_operand),
        .sqrt_result  (sqrt_result),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_id      (resp_id),
        .resp_nv      (resp_nv),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stand-in square root: exact for the directed values, scrambled otherwise.
    function automatic logic [31:0] sqrt_fn(input logic [31:0] v);
        case (v)
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            32'h40400000: return 32'h3fddb3d7;
            32'h40490fda: return 32'h3fe2dfc5;
            32'h40800000: return 32'h40000000;
            default:      return {v[15:0], v[31:16]} ^ 32'hA5A50F0F;
        endcase
    endfunction

    always @(posedge clk) sqrt_result <= sqrt_fn(sqrt_operand);

    function automatic bit ref_nv(input logic [31:0] v);
        bit neg;
        bit zero;
        bit nan;
        neg  = v[31];
        zero = (v[30:0] == 31'd0);
        nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        return neg && !zero && !nan;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v == NR'(1 << i)) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        fifoq.delete();
        ptr     = 0;
        last_op = 32'h0;
    endtask

    task automatic model_comb();
        int outstanding;
        exp_gnt     = -1;
        outstanding = inflight.size() + fifoq.size();
        if (!rst && outstanding < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (ptr + k) % NR;
                if (exp_gnt < 0 && pend[idx]) exp_gnt = idx;
            end
        end
    endtask

    task automatic model_seq();
        op_t o;
        if (rst) return;
        if (fifoq.size() > 0 && resp_ready) void'(fifoq.pop_front());
        for (int k = 0; k < inflight.size(); k++) begin
            inflight[k].rem = inflight[k].rem - 1;
        end
        while (inflight.size() > 0 && inflight[0].rem == 0) begin
            fifoq.push_back(inflight.pop_front());
        end
        if (exp_gnt >= 0) begin
            o.data = sqrt_fn(pdata[exp_gnt]);
            o.id   = exp_gnt;
            o.nv   = ref_nv(pdata[exp_gnt]);
            o.rem  = LAT + 1;
            inflight.push_back(o);
            last_op       = pdata[exp_gnt];
            pend[exp_gnt] = 1'b0;
            ptr           = (exp_gnt + 1) % NR;
        end
    endtask

    task automatic cycle();
        logic [NR-1:0] exp_rdy;
        op_t           r;
        int            g;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = pend[i];
            req_data[32*i +: 32]  = pdata[i];
        end
        model_comb();
        exp_rdy = '0;
        if (exp_gnt >= 0) exp_rdy[exp_gnt] = 1'b1;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(fifoq.size() > 0));
        if (fifoq.size() > 0) begin
            check("resp_data", resp_data, fifoq[0].data);
            check("resp_id", 32'(resp_id), 32'(fifoq[0].id));
            check("resp_nv", 32'(resp_nv), 32'(fifoq[0].nv));
        end
        check("busy", 32'(busy),
              32'(inflight.size() > 0 || fifoq.size() > 0));
        check("sqrt_operand", sqrt_operand, last_op);
        if (resp_valid && resp_ready) begin
            r.data = resp_data;
            r.id   = int'(resp_id);
            r.nv   = resp_nv;
            r.rem  = 0;
            resp_log.push_back(r);
        end
        g = oh2idx(req_ready);
        if (g >= 0) grant_log.push_back(g);
        @(posedge clk);
        model_seq();
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(3) == 0) return specials[$urandom_range(7)];
        return $urandom;
    endfunction

    task automatic refill(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            if (mask[i] && !pend[i]) begin
                pend[i]  = 1'b1;
                pdata[i] = rnd_op();
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int n0;
        logic [31:0] t2_data [4];
        t2_data[0] = 32'h40400000;
        t2_data[1] = 32'h40800000;
        t2_data[2] = 32'h3fddb3d7;
        t2_data[3] = 32'h3fe2dfc5;
        specials[0] = 32'h00000000;
        specials[1] = 32'h80000000;
        specials[2] = 32'hFF800000;
        specials[3] = 32'h7F800000;
        specials[4] = 32'h7FC00000;
        specials[5] = 32'hFFC00001;
        specials[6] = 32'hC0800000;
        specials[7] = 32'h41100000;
        rst        = 1'b1;
        resp_ready = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        for (int i = 0; i < NR; i++) pdata[i] = 32'h0;
        do_reset();

        // 9.0 from requester 0 alone.
        resp_ready = 1'b1;
        resp_log.delete();
        pend[0]  = 1'b1;
        pdata[0] = 32'h41100000;
        run(6);
        check("t1_count", 32'(resp_log.size()), 32'd1);
        if (resp_log.size() > 0) begin
            check("t1_data", resp_log[0].data, 32'h40400000);
            check("t1_nv", 32'(resp_log[0].nv), 32'd0);
        end

        // All four at once from a fresh pointer.
        do_reset();
        resp_log.delete();
        grant_log.delete();
        pdata[0] = 32'h41100000;
        pdata[1] = 32'h41800000;
        pdata[2] = 32'h40400000;
        pdata[3] = 32'h40490fda;
        for (int i = 0; i < NR; i++) pend[i] = 1'b1;
        run(10);
        check("t2_count", 32'(resp_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < resp_log.size(); k++) begin
            check("t2_data", resp_log[k].data, t2_data[k]);
            check("t2_id", 32'(resp_log[k].id), 32'(k));
            check("t2_grant", 32'(grant_log[k]), 32'(k));
        end

        // Credit limit with a stalled consumer.
        resp_ready = 1'b0;
        grant_log.delete();
        for (int k = 0; k < 8; k++) begin
            refill('1);
            cycle();
        end
        check("t3_grants", 32'(grant_log.size()), 32'(DEPTH));
        resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            refill('1);
            cycle();
        end
        run(12);

        // Invalid-operation flag from requester 1.
        resp_log.delete();
        pend[1] = 1'b1; pdata[1] = 32'hC0800000; run(5);
        pend[1] = 1'b1; pdata[1] = 32'h80000000; run(5);
        pend[1] = 1'b1; pdata[1] = 32'hFF800000; run(5);
        check("t4_count", 32'(resp_log.size()), 32'd3);
        if (resp_log.size() == 3) begin
            check("t4_id", 32'(resp_log[0].id), 32'd1);
            check("t4_nv_neg", 32'(resp_log[0].nv), 32'd1);
            check("t4_nv_negzero", 32'(resp_log[1].nv), 32'd0);
            check("t4_nv_neginf", 32'(resp_log[2].nv), 32'd1);
        end

        // Asynchronous reset with work in flight and buffered.
        resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pend[i]  = 1'b1;
            pdata[i] = rnd_op();
        end
        run(3);
        check("t5_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        run(2);
        rst        = 1'b0;
        resp_ready = 1'b1;
        resp_log.delete();
        run(10);
        check("t5_no_resp", 32'(resp_log.size()), 32'd0);
        grant_log.delete();
        refill(4'b1101);
        cycle();
        check("t5_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1),
              32'd0);
        run(8);

        // Two persistent requesters alternate.
        grant_log.delete();
        for (int k = 0; k < 12; k++) begin
            refill(4'b0101);
            cycle();
        end
        check("t6_count", 32'(grant_log.size()), 32'd12);
        for (int k = 1; k < grant_log.size(); k++) begin
            check("t6_alt", 32'(grant_log[k] != grant_log[k-1]), 32'd1);
            check("t6_set", 32'(grant_log[k] == 0 || grant_log[k] == 2), 32'd1);
        end
        run(8);

        // Random traffic with random back-pressure.
        n0 = checks;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = rnd_op();
                end
            end
            resp_ready = ($urandom_range(2) != 0);
            cycle();
        end
        resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        run(10);
        check("rand_ran", 32'(checks > n0), 32'd1);
        check("drain_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
